multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle sequencing FSM for the MIPS datapath. It drives the shared memory/ALU/register-file control lines over several cycles per instruction.
- Decodes opcode/funct from the instruction register.
- Waits on a memory ready handshake and halts on a memory timeout.
- Sits between the instruction register/ALU zero flag and the datapath mux/enable inputs.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ready in any memory state; 0 disables the timeout
TO_WIDTH, 8, width of the wait counter; must satisfy TIMEOUT < 2**TO_WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instruction[31:26] from IR, stable from DECODE onward
funct  input  6  instruction[5:0] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_en  output  1  PC load enable = pc_write | (branch & zero)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  IR load enable
mem_write  output  1  memory write request
mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = memory data
reg_dst  output  1  destination register: 0 = rt, 1 = rd
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A operand: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_control  output  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
illegal_op  output  1  one-cycle pulse: unsupported opcode/funct decoded
instr_done  output  1  one-cycle pulse in the final state of each instruction
bus_error  output  1  sticky flag: memory timeout, controller halted
state  output  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - state = FETCH, wait counter = 0, bus_error = 0.
  - While reset is high, all outputs except state are forced to 0.
- Unless noted, outputs are Moore decodes of state; any output not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write and pc_write assert only in a cycle where mem_ready=1; the FSM then moves to DECODE.
  - Otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut). Next state:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 with funct 100000/100010/100100/100101/101010 -> EXECUTE
  - 000100 -> BEQ
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode, or R-type with any other funct: illegal_op=1 this cycle -> FETCH; no register or memory side effects.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Stays until mem_ready=1 -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWR: iord=1, mem_write held at 1 until the mem_ready cycle. Then instr_done=1 -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_control by funct: add 010, sub 110, and 000, or 001, slt 111. -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, instr_done=1 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Wait counter and timeout:
  - Counter clears on every state change and increments on each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT while mem_ready=0: bus_error<=1 and the next state is HALT.
  - If mem_ready=1 in that same cycle, the access completes normally and no error is raised.
- HALT: all outputs 0 except bus_error=1. Exited only by reset.
- Cycle counts, assuming mem_ready is already high:
  - lw = 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB)
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
- Reset mid-instruction aborts immediately. No write enables are asserted during reset or on the first edge after reset release.

Test Plan:
- lw (opcode 100011), mem_ready held 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 and mem_to_reg=1 only in MEMWB; instr_done pulses once.
- R-type sub (funct 100010) -> alu_control=110 in EXECUTE; reg_dst=1 and reg_write=1 in ALUWB; 4 cycles total.
- beq with zero=1 -> pc_en=1 in BEQ with pc_src=01; repeat with zero=0 -> pc_en=0 in BEQ.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write stays 1 for 4 cycles and drops after the ready cycle; next state FETCH.
- Opcode 111111, then R-type funct 000000 -> illegal_op pulses one cycle in DECODE; no reg_write/mem_write; FSM returns to FETCH.
- TIMEOUT=4 and mem_ready stuck 0 in FETCH -> bus_error=1 after 4 wait cycles; FSM in HALT with all enables 0 until reset. Reset asserted mid-MEMRD -> immediate FETCH with outputs 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over several cycles per instruction, with a memory-ready wait timeout that halts the controller.
module multicycle_controller #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic       instr_done,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

  logic [3:0]          next_state;
  logic [TO_WIDTH-1:0] wait_cnt;
  logic [TO_WIDTH-1:0] wait_cnt_inc;
  logic                wait_state;
  logic                timeout_hit;
  logic                r_legal;
  logic                op_legal;
  logic                pc_write;
  logic                branch;

  assign r_legal  = (opcode == OP_RTYPE) &&
                    ((funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                     (funct == 6'b100101) || (funct == 6'b101010));
  assign op_legal = r_legal || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

  // The timeout fires on the cycle that would be the TIMEOUT-th unanswered wait cycle.
  assign wait_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_cnt_inc = wait_cnt + {{(TO_WIDTH-1){1'b0}}, 1'b1};
  assign timeout_hit  = (TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt_inc == TO_LIMIT);

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)        next_state = S_DECODE;
        else if (timeout_hit) next_state = S_HALT;
        else                  next_state = S_FETCH;
      end
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) next_state = S_MEMADR;
        else if (r_legal)                         next_state = S_EXECUTE;
        else if (opcode == OP_BEQ)                next_state = S_BEQ;
        else if (opcode == OP_ADDI)               next_state = S_ADDIEX;
        else if (opcode == OP_J)                  next_state = S_JUMP;
        else                                      next_state = S_FETCH;
      end
      S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)        next_state = S_MEMWB;
        else if (timeout_hit) next_state = S_HALT;
        else                  next_state = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready)        next_state = S_FETCH;
        else if (timeout_hit) next_state = S_HALT;
        else                  next_state = S_MEMWR;
      end
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_FETCH;
    endcase
  end

  // State register, wait counter and sticky bus error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= {TO_WIDTH{1'b0}};
      bus_error <= 1'b0;
    end else begin
      state <= next_state;
      if (timeout_hit) bus_error <= 1'b1;
      if (next_state != state)           wait_cnt <= {TO_WIDTH{1'b0}};
      else if (wait_state && !mem_ready) wait_cnt <= wait_cnt_inc;
    end
  end

  // Datapath control decode; everything except state is held low during reset.
  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          alu_src_b   = 2'b01;
          alu_control = 3'b010;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = 3'b010;
          illegal_op  = !op_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = 3'b010;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          case (funct)
            6'b100010: alu_control = 3'b110;
            6'b100100: alu_control = 3'b000;
            6'b100101: alu_control = 3'b001;
            6'b101010: alu_control = 3'b111;
            default:   alu_control = 3'b010;
          endcase
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          branch      = 1'b1;
          pc_src      = 2'b01;
          instr_done  = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: pc_write = 1'b0;
      endcase
    end else begin
      pc_write = 1'b0;
    end
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model builds the expected
// per-cycle control vector, checked every cycle, plus literal pins on lengths and pulses.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal_op, instr_done, bus_error;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .ir_write(ir_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op),
    .instr_done(instr_done), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2, T_MEMRD = 4'd3,
                         T_MEMWB = 4'd4, T_MEMWR = 4'd5, T_EXECUTE = 4'd6, T_ALUWB = 4'd7,
                         T_BEQ = 4'd8, T_ADDIEX = 4'd9, T_ADDIWB = 4'd10, T_JUMP = 4'd11,
                         T_HALT = 4'd12;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

  typedef struct packed {
    logic       pc_en, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal_op, instr_done, bus_error;
    logic [3:0] state;
  } ctl_t;

  int checks = 0;
  int passes = 0;
  int ilen = 0, last_len = 0, done_cnt = 0, mw_cnt = 0, ill_cnt = 0, wr_cnt = 0;

  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b100011) return C_LW;
    if (op == 6'b101011) return C_SW;
    if (op == 6'b000100) return C_BEQ;
    if (op == 6'b001000) return C_ADDI;
    if (op == 6'b000010) return C_J;
    if (op == 6'b000000 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a))
      return C_R;
    return C_ILL;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic ctl_t model(input logic [3:0] st, input logic mr, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z);
    ctl_t c = '0;
    c.state = st;
    case (st)
      T_FETCH:   begin c.alu_src_b = 2'b01; c.alu_control = 3'b010; c.ir_write = mr; c.pc_en = mr; end
      T_DECODE:  begin c.alu_src_b = 2'b11; c.alu_control = 3'b010; c.illegal_op = (cls(op, fn) == C_ILL); end
      T_MEMADR,
      T_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010; end
      T_MEMRD:   c.iord = 1'b1;
      T_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      T_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = mr; end
      T_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_control = r_alu(fn); end
      T_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      T_BEQ:     begin c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01;
                       c.pc_en = z; c.instr_done = 1'b1; end
      T_ADDIWB:  begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      T_JUMP:    begin c.pc_src = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1; end
      T_HALT:    c.bus_error = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Activity monitor feeding the literal instruction-level checks.
  always @(negedge clk) begin
    if (!reset) begin
      ilen <= ir_write ? 1 : ilen + 1;
      if (instr_done) begin
        done_cnt <= done_cnt + 1;
        last_len <= ilen + 1;
      end
      if (mem_write) mw_cnt <= mw_cnt + 1;
      if (illegal_op) ill_cnt <= ill_cnt + 1;
      if (reg_write || mem_write) wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // One cycle: apply mem_ready, compare the whole control vector at negedge, advance.
  task automatic cycle_with(input ctl_t e, input logic mr);
    ctl_t act;
    mem_ready = mr;
    @(negedge clk);
    act = {pc_en, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, pc_src, alu_control, illegal_op, instr_done, bus_error, state};
    checks++;
    if (act === e) passes++;
    else $display("FAIL cycle t=%0t: got state=%0d ctl=%h, required state=%0d ctl=%h",
                  $time, act.state, act[21:4], e.state, e[21:4]);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] st, input logic mr);
    cycle_with(model(st, mr, opcode, funct, zero), mr);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int fw, input int mw);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < fw; i++) step(T_FETCH, 1'b0);
    step(T_FETCH, 1'b1);
    step(T_DECODE, 1'b1);
    case (cls(op, fn))
      C_LW: begin
        step(T_MEMADR, 1'b1);
        for (int i = 0; i < mw; i++) step(T_MEMRD, 1'b0);
        step(T_MEMRD, 1'b1);
        step(T_MEMWB, 1'b1);
      end
      C_SW: begin
        step(T_MEMADR, 1'b1);
        for (int i = 0; i < mw; i++) step(T_MEMWR, 1'b0);
        step(T_MEMWR, 1'b1);
      end
      C_R:    begin step(T_EXECUTE, 1'b1); step(T_ALUWB, 1'b1); end
      C_BEQ:  step(T_BEQ, 1'b1);
      C_ADDI: begin step(T_ADDIEX, 1'b1); step(T_ADDIWB, 1'b1); end
      C_J:    step(T_JUMP, 1'b1);
      default: ;
    endcase
  endtask

  logic [5:0] rfun [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  int base_done, base_mw, base_ill, base_wr;

  initial begin
    cycle_with('0, 1'b1);
    cycle_with('0, 1'b0);
    reset = 1'b0;

    base_done = done_cnt; base_wr = wr_cnt;
    run(6'b100011, 6'h00, 1'b0, 0, 0);
    chk("lw_len", last_len, 5);
    chk("lw_done_pulses", done_cnt - base_done, 1);
    chk("lw_writes", wr_cnt - base_wr, 1);

    run(6'b000000, 6'b100010, 1'b0, 0, 0);
    chk("sub_len", last_len, 4);
    foreach (rfun[i]) run(6'b000000, rfun[i], 1'b1, 0, 0);

    run(6'b000100, 6'h00, 1'b1, 0, 0);
    chk("beq_len", last_len, 3);
    run(6'b000100, 6'h00, 1'b0, 1, 0);

    base_mw = mw_cnt;
    run(6'b101011, 6'h00, 1'b0, 0, 3);
    chk("sw_memwrite_cycles", mw_cnt - base_mw, 4);
    chk("sw_back_to_fetch", state, T_FETCH);

    base_ill = ill_cnt; base_wr = wr_cnt;
    run(6'b111111, 6'h00, 1'b0, 0, 0);
    run(6'b000000, 6'b000000, 1'b0, 0, 0);
    chk("illegal_pulses", ill_cnt - base_ill, 2);
    chk("illegal_no_writes", wr_cnt - base_wr, 0);

    run(6'b001000, 6'h00, 1'b0, 0, 0);
    chk("addi_len", last_len, 4);
    run(6'b000010, 6'h00, 1'b0, 0, 0);
    chk("j_len", last_len, 3);

    // Three unanswered waits is one short of the limit: both accesses must complete.
    run(6'b100011, 6'h00, 1'b0, 3, 3);
    chk("no_timeout_at_limit_minus_1", bus_error, 0);

    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) step(T_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) step(T_HALT, 1'b1);
    chk("fetch_timeout_bus_error", bus_error, 1);

    reset = 1'b1;
    cycle_with('0, 1'b1);
    reset = 1'b0;
    chk("bus_error_cleared", bus_error, 0);

    opcode = 6'b100011;
    step(T_FETCH, 1'b1); step(T_DECODE, 1'b1); step(T_MEMADR, 1'b1);
    step(T_MEMRD, 1'b0); step(T_MEMRD, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_state", state, T_FETCH);
    chk("abort_outputs", int'({pc_en, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
                               alu_src_a, alu_src_b, pc_src, alu_control, illegal_op,
                               instr_done, bus_error}), 0);
    @(posedge clk); #1;
    cycle_with('0, 1'b1);
    reset = 1'b0;
    run(6'b000010, 6'h00, 1'b0, 0, 0);

    opcode = 6'b100011;
    step(T_FETCH, 1'b1); step(T_DECODE, 1'b1); step(T_MEMADR, 1'b1);
    for (int i = 0; i < 4; i++) step(T_MEMRD, 1'b0);
    step(T_HALT, 1'b1); step(T_HALT, 1'b0);
    chk("memrd_timeout_bus_error", bus_error, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
